// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential square-root unit: state encoding and default width.
package sqrt_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-recurrence iteration: folds two radicand bits into the remainder
// and retires one root bit, MSB first.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic [RW:0]   rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [RW:0]   rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+1:0] w_acc;
  logic [RW+1:0] w_sub;
  logic [RW+1:0] w_trial;
  logic          w_ge;
  logic          w_unused;

  // Before any step the remainder is <= 2*root, so rem_i[RW] and root_i[RW-1] are always
  // zero here; dropping them keeps the trial at RW+2 bits without losing information.
  assign w_acc   = {rem_i[RW-1:0], bits_i};
  assign w_sub   = {root_i, 2'b01};
  assign w_trial = w_acc - w_sub;
  assign w_ge    = (w_acc >= w_sub);

  assign rem_o  = w_ge ? w_trial[RW:0] : w_acc[RW:0];
  assign root_o = {root_i[RW-2:0], w_ge};

  assign w_unused = ^{rem_i[RW], root_i[RW-1], w_trial[RW+1], w_acc[RW+1]};

endmodule

// File: rtl/sqrt_seq_unit.sv
// Sequential integer square root: one root bit per clock, WIDTH/2 iterations per job,
// result registers updated only when a job completes.
module sqrt_seq_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     radicand_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [WIDTH/2-1:0]   root_o,
  output logic [WIDTH/2:0]     rem_o
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_last;

  logic [WIDTH-1:0] r_rad;
  logic [RW:0]      r_rem;
  logic [RW-1:0]    r_root;
  logic [CW-1:0]    r_cnt;
  logic [RW:0]      r_rem_res;
  logic [RW-1:0]    r_root_res;

  logic [RW:0]      w_rem_nxt;
  logic [RW-1:0]    w_root_nxt;

  assign w_last = (r_cnt == '0);

  sqrt_step #(.RW(RW)) u_step (
    .rem_i  (r_rem),
    .root_i (r_root),
    .bits_i (r_rad[WIDTH-1 -: 2]),
    .rem_o  (w_rem_nxt),
    .root_o (w_root_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs depend on state only, so start_i never reaches an output combinationally.
  always_comb begin
    w_state_nxt = IDLE;
    w_accept    = 1'b0;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i && !clear_i) begin
          w_state_nxt = CALC;
          w_accept    = 1'b1;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (clear_i)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
        else             w_state_nxt = CALC;
      end
      DONE: begin
        ready_o = 1'b1;
        valid_o = 1'b1;
        if (start_i && !clear_i) begin
          w_state_nxt = CALC;
          w_accept    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_cnt      <= '0;
      r_rem_res  <= '0;
      r_root_res <= '0;
    end else if (w_accept) begin
      r_rad  <= radicand_i;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= CW'(RW - 1);
    end else if (r_state == CALC && !clear_i) begin
      r_rad  <= {r_rad[WIDTH-3:0], 2'b00};
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt;
      r_cnt  <= r_cnt - 1'b1;
      if (w_last) begin
        r_rem_res  <= w_rem_nxt;
        r_root_res <= w_root_nxt;
      end
    end
  end

  assign root_o = r_root_res;
  assign rem_o  = r_rem_res;

endmodule

// File: tb/tb_sqrt_seq_unit.sv
// Self-checking bench for sqrt_seq_unit (WIDTH=16): directed vector table, multi-cycle
// corner sequences and a randomized back-to-back stream against an arithmetic model.
module tb_sqrt_seq_unit;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;
  localparam int NRAND = 3000;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic             clear_i;
  logic [WIDTH-1:0] radicand_i;
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [RW-1:0]    root_o;
  logic [RW:0]      rem_o;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [WIDTH-1:0] rad;
    logic [RW-1:0]    root;
    logic [RW:0]      rem;
  } vec_t;

  vec_t vecs[10];

  sqrt_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .clear_i    (clear_i),
    .radicand_i (radicand_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .root_o     (root_o),
    .rem_o      (rem_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void ref_sqrt(input longint x, output longint r, output longint m);
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    m = x - r * r;
  endfunction

  // Presents a request at the current negedge; edges counts rising edges from the
  // accepting edge (inclusive) until valid_o is seen, bounded at 40.
  task automatic launch(input logic [WIDTH-1:0] x, output int edges);
    start_i    = 1'b1;
    radicand_i = x;
    tick();
    start_i    = 1'b0;
    radicand_i = WIDTH'($urandom);
    edges      = 1;
    while (valid_o !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int     e;
    int     nv;
    longint er, em, cap_root, cap_rem;
    logic [WIDTH-1:0] x;
    int     k;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{16'd144,   8'd12,  9'd0};
    vecs[1] = '{16'd0,     8'd0,   9'd0};
    vecs[2] = '{16'd1,     8'd1,   9'd0};
    vecs[3] = '{16'd145,   8'd12,  9'd1};
    vecs[4] = '{16'd65535, 8'd255, 9'd510};
    vecs[5] = '{16'd100,   8'd10,  9'd0};
    vecs[6] = '{16'd50,    8'd7,   9'd1};
    vecs[7] = '{16'd2,     8'd1,   9'd1};
    vecs[8] = '{16'd65025, 8'd255, 9'd0};
    vecs[9] = '{16'd65024, 8'd254, 9'd508};

    rst_n      = 1'b0;
    start_i    = 1'b0;
    clear_i    = 1'b0;
    radicand_i = '0;

    @(negedge clk);
    check("reset_ready", ready_o, 1);
    check("reset_busy",  busy_o,  0);
    check("reset_valid", valid_o, 0);
    check("reset_root",  root_o,  0);
    check("reset_rem",   rem_o,   0);
    rst_n = 1'b1;
    tick();

    // Directed table, each job started from IDLE.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].rad, e);
      check($sformatf("vec%0d_latency", i), e, RW + 1);
      check($sformatf("vec%0d_root", i), root_o, vecs[i].root);
      check($sformatf("vec%0d_rem", i),  rem_o,  vecs[i].rem);
      tick();
      check($sformatf("vec%0d_strobe_len", i), valid_o, 0);
      check($sformatf("vec%0d_idle_ready", i), ready_o, 1);
    end

    // Back-to-back: new request during the DONE cycle of a 144 job.
    launch(16'd144, e);
    check("b2b_first_root", root_o, 12);
    check("b2b_ready_in_done", ready_o, 1);
    launch(16'd100, e);
    check("b2b_gap", e, RW + 1);
    check("b2b_root", root_o, 10);
    check("b2b_rem",  rem_o,  0);
    tick();

    // start_i pulsed mid-calculation must be ignored.
    start_i    = 1'b1;
    radicand_i = 16'd50;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    check("ign_busy", busy_o, 1);
    check("ign_ready", ready_o, 0);
    start_i    = 1'b1;
    radicand_i = 16'd9;
    tick();
    start_i = 1'b0;
    nv = 0; cap_root = -1; cap_rem = -1;
    for (int c = 0; c < 20; c++) begin
      if (valid_o === 1'b1) begin
        nv++;
        cap_root = root_o;
        cap_rem  = rem_o;
      end
      tick();
    end
    check("ign_valid_count", nv, 1);
    check("ign_root", cap_root, 7);
    check("ign_rem",  cap_rem,  1);

    // clear_i in CALC cycle 4: abort, keep prior result (7,1).
    start_i    = 1'b1;
    radicand_i = 16'd144;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_ready", ready_o, 1);
    check("clr_busy",  busy_o,  0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid_o === 1'b1) nv++;
      tick();
    end
    check("clr_no_valid", nv, 0);
    check("clr_root_hold", root_o, 7);
    check("clr_rem_hold",  rem_o,  1);

    // Asynchronous reset in CALC cycle 3.
    start_i    = 1'b1;
    radicand_i = 16'd144;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", ready_o, 1);
    check("rst_mid_busy",  busy_o,  0);
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_root",  root_o,  0);
    check("rst_mid_rem",   rem_o,   0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'd145, e);
    check("rst_after_latency", e, RW + 1);
    check("rst_after_root", root_o, 12);
    check("rst_after_rem",  rem_o,  1);

    // Randomized back-to-back stream against the arithmetic model.
    for (int i = 0; i < NRAND; i++) begin
      k = int'($urandom_range(0, 255));
      case (i % 4)
        0: x = WIDTH'($urandom_range(0, 65535));
        1: x = WIDTH'(k * k + int'($urandom_range(0, 2 * k)));
        2: x = (k == 0) ? WIDTH'(65535) : WIDTH'(k * k - 1);
        default: x = WIDTH'($urandom);
      endcase
      if (i == 0) x = 16'hFFFF;
      if (i == 1) x = 16'h0000;
      launch(x, e);
      if (e >= 40) begin
        check("rand_timeout", e, RW + 1);
        break;
      end
      ref_sqrt(longint'(x), er, em);
      check("rand_root", root_o, er);
      check("rand_rem",  rem_o,  em);
      check("rand_identity",
            (longint'(root_o) * longint'(root_o) + longint'(rem_o) == longint'(x)) &&
            (longint'(rem_o) <= 2 * longint'(root_o)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
